// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - 16x oversampled UART receiver with majority-vote sampling and a show-ahead frame FIFO
module uart_rx_frame #(
  parameter int CLK_FREQ    = 20000000,
  parameter int BAUDRATE    = 9600,
  parameter int N_DATA_BITS = 8,
  parameter int LSB_FIRST   = 0,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [7:0]                    rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_overrun,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = (CLK_FREQ + 8 * BAUDRATE) / (16 * BAUDRATE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(N_DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 r_state, w_state_nx;
  logic [1:0]             r_sync;
  logic                   w_rxs;
  logic [TW-1:0]          r_tick;
  logic                   w_tick, w_eval, w_bit_end, w_maj, w_last_stop, w_par_exp;
  logic [3:0]             r_s;
  logic [1:0]             r_samp;
  logic [N_DATA_BITS-1:0] r_shift, w_shift_nx;
  logic [BW-1:0]          r_bitcnt;
  logic                   r_stopcnt, r_par_err, r_frm_err;
  logic                   r_push, r_push_pe, r_push_fe;
  logic [7:0]             r_push_data;

  logic [7:0]             r_mem_data [FIFO_DEPTH];
  logic                   r_mem_pe   [FIFO_DEPTH];
  logic                   r_mem_fe   [FIFO_DEPTH];
  logic [PW-1:0]          r_wptr, r_rptr;
  logic [PW:0]            r_count;
  logic                   w_full, w_pop, w_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], uart_rx};
  end
  assign w_rxs = r_sync[1];

  // Tick phase is re-aligned to the start-bit edge so sample points sit mid-bit.
  assign w_tick = (r_tick == TW'(DIV - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_tick <= '0;
    else if (r_state == S_IDLE && !w_rxs) r_tick <= '0;
    else if (w_tick)                      r_tick <= '0;
    else                                  r_tick <= r_tick + 1'b1;
  end

  assign w_eval      = w_tick && (r_s == 4'd9);
  assign w_bit_end   = w_tick && (r_s == 4'd15);
  assign w_maj       = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxs) | (r_samp[1] & w_rxs);
  assign w_last_stop = (r_stopcnt == 1'(STOP_BITS - 1));
  assign w_par_exp   = (^r_shift) ^ (PARITY_ODD != 0);

  if (LSB_FIRST != 0) begin : g_lsb_first
    assign w_shift_nx = {w_maj, r_shift[N_DATA_BITS-1:1]};
  end else begin : g_msb_first
    assign w_shift_nx = {r_shift[N_DATA_BITS-2:0], w_maj};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (!w_rxs) w_state_nx = S_START;
      S_START: begin
        if (w_eval && w_maj) w_state_nx = S_IDLE;
        else if (w_bit_end)  w_state_nx = S_DATA;
      end
      S_DATA:   if (w_bit_end && r_bitcnt == BW'(N_DATA_BITS - 1))
                  w_state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_bit_end) w_state_nx = S_STOP;
      S_STOP:   if (w_eval && w_last_stop) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s         <= '0;
      r_samp      <= 2'b11;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_stopcnt   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frm_err   <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_push_pe   <= 1'b0;
      r_push_fe   <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (r_state == S_IDLE) begin
        r_s       <= '0;
        r_shift   <= '0;
        r_bitcnt  <= '0;
        r_stopcnt <= 1'b0;
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
      end else if (w_tick) begin
        r_s <= r_s + 4'd1;
        if (r_s == 4'd7) r_samp[0] <= w_rxs;
        if (r_s == 4'd8) r_samp[1] <= w_rxs;
        if (r_s == 4'd9) begin
          case (r_state)
            S_DATA:   r_shift   <= w_shift_nx;
            S_PARITY: r_par_err <= (w_maj != w_par_exp);
            S_STOP: begin
              // Push at mid-stop so a following start edge is never missed.
              if (w_last_stop) begin
                r_push      <= 1'b1;
                r_push_data <= 8'(r_shift);
                r_push_pe   <= r_par_err;
                r_push_fe   <= r_frm_err | ~w_maj;
              end
              if (!w_maj) r_frm_err <= 1'b1;
            end
            default: ;
          endcase
        end
        if (r_s == 4'd15) begin
          if (r_state == S_DATA) r_bitcnt  <= r_bitcnt + 1'b1;
          if (r_state == S_STOP) r_stopcnt <= r_stopcnt + 1'b1;
        end
      end
    end
  end

  assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
  assign rx_valid   = (r_count != '0);
  assign w_pop      = rx_valid && rx_ready;
  assign w_wr       = r_push && (!w_full || w_pop);
  assign rx_overrun = r_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_data[r_wptr] <= r_push_data;
      r_mem_pe[r_wptr]   <= r_push_pe;
      r_mem_fe[r_wptr]   <= r_push_fe;
    end
  end

  assign rx_data       = rx_valid ? r_mem_data[r_rptr] : 8'h00;
  assign rx_parity_err = rx_valid & r_mem_pe[r_rptr];
  assign rx_frame_err  = rx_valid & r_mem_fe[r_rptr];
  assign rx_busy       = (r_state != S_IDLE);
  assign fifo_count    = r_count;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - randomized scoreboard bench for uart_rx_frame (8N1 MSB-first and 5O2 LSB-first instances)
module tb_uart_rx_frame;

  localparam int CLK_FREQ = 8000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
  localparam int BIT      = 16 * DIV;

  logic       clk, rst;
  logic       line_a, line_b, ready_a, ready_b;
  logic       valid_a, pe_a, fe_a, ovr_a, busy_a;
  logic       valid_b, pe_b, fe_b, ovr_b, busy_b;
  logic [7:0] data_a, data_b;
  logic [2:0] cnt_a, cnt_b;

  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD)) dut_a (
    .clk(clk), .rst(rst), .uart_rx(line_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .rx_data(data_a), .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_overrun(ovr_a),
    .rx_busy(busy_a), .fifo_count(cnt_a)
  );

  uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .N_DATA_BITS(5), .LSB_FIRST(1),
                  .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .uart_rx(line_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .rx_data(data_b), .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_overrun(ovr_b),
    .rx_busy(busy_b), .fifo_count(cnt_b)
  );

  int n_checks, n_errors;
  int cyc = 0;
  int t_mid_a, t_rise_a = -1;
  int ovr_cnt_a = 0, ovr_cnt_b = 0;
  int ovr_base, exp_ovr;
  logic prev_va = 1'b0;
  logic done_a;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [9:0] ea, eb, head;
  logic [7:0] seq[5];
  logic [7:0] d, ra;
  logic [4:0] rb;
  logic       fb;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a && !prev_va) t_rise_a = cyc;
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
      if (valid_a && ready_a) begin
        if (exp_a.size() == 0) check_eq("a_unexpected_pop", 32'(1), 32'(0));
        else begin
          ea = exp_a.pop_front();
          check_eq("a_data", 32'(data_a), 32'(ea[9:2]));
          check_eq("a_flags", 32'({pe_a, fe_a}), 32'(ea[1:0]));
        end
      end
      if (valid_b && ready_b) begin
        if (exp_b.size() == 0) check_eq("b_unexpected_pop", 32'(1), 32'(0));
        else begin
          eb = exp_b.pop_front();
          check_eq("b_data", 32'(data_b), 32'(eb[9:2]));
          check_eq("b_flags", 32'({pe_b, fe_b}), 32'(eb[1:0]));
        end
      end
    end
    prev_va = valid_a;
  end

  task automatic drive_a(input logic v, input int n);
    @(posedge clk); #1; line_a = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic drive_b(input logic v, input int n);
    @(posedge clk); #1; line_b = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_a(input logic [7:0] dd, input logic stop_v);
    drive_a(1'b0, BIT);
    for (int i = 7; i >= 0; i--) drive_a(dd[i], BIT);
    t_mid_a = cyc + BIT / 2;
    drive_a(stop_v, BIT);
  endtask

  task automatic send_b(input logic [4:0] dd, input logic flip);
    drive_b(1'b0, BIT);
    for (int i = 0; i < 5; i++) drive_b(dd[i], BIT);
    drive_b(~(^dd) ^ flip, BIT);
    drive_b(1'b1, BIT);
    drive_b(1'b1, BIT);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 20 * BIT) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check_eq(tag, 32'(exp_a.size() + exp_b.size()), 32'(0));
    check_eq({tag, "_cnt"}, 32'({cnt_a, cnt_b}), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(valid_a), 32'(0));
    check_eq({tag, "_data"},  32'(data_a),  32'(0));
    check_eq({tag, "_pe"},    32'(pe_a),    32'(0));
    check_eq({tag, "_fe"},    32'(fe_a),    32'(0));
    check_eq({tag, "_ovr"},   32'(ovr_a),   32'(0));
    check_eq({tag, "_busy"},  32'(busy_a),  32'(0));
    check_eq({tag, "_count"}, 32'(cnt_a),   32'(0));
    check_eq({tag, "_b"},     32'({valid_b, busy_b, cnt_b, data_b}), 32'(0));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    line_a = 1'b1; line_b = 1'b1;
    ready_a = 1'b0; ready_b = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    drive_a(1'b1, 2 * BIT);

    seq = '{8'h57, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 5; i++) begin
      exp_a.push_back({seq[i], 2'b00});
      send_a(seq[i], 1'b1);
      if (i == 0)
        check_eq("first_valid_latency",
                 32'((t_rise_a >= t_mid_a) && (t_rise_a - t_mid_a <= BIT + 3)), 32'(1));
    end
    drive_a(1'b1, BIT);
    wait_drain("drain_default");

    exp_b.push_back({3'b000, 5'h15, 1'b0, 1'b0});
    send_b(5'h15, 1'b0);
    exp_b.push_back({3'b000, 5'h15, 1'b1, 1'b0});
    send_b(5'h15, 1'b1);
    drive_b(1'b1, BIT);
    wait_drain("drain_parity");

    exp_a.push_back({8'hA5, 1'b0, 1'b1});
    send_a(8'hA5, 1'b0);
    drive_a(1'b1, 2 * BIT);
    exp_a.push_back({8'h3C, 2'b00});
    send_a(8'h3C, 1'b1);
    drive_a(1'b1, BIT);
    wait_drain("drain_frame_err");

    drive_a(1'b0, 4 * DIV);
    @(negedge clk);
    check_eq("glitch_busy_high", 32'(busy_a), 32'(1));
    drive_a(1'b1, 2 * BIT);
    @(negedge clk);
    check_eq("glitch_busy_low", 32'(busy_a), 32'(0));
    check_eq("glitch_no_push", 32'(cnt_a), 32'(0));

    ready_a = 1'b0;
    ovr_base = ovr_cnt_a;
    exp_ovr = 0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      if (exp_a.size() < 4) exp_a.push_back({d, 2'b00});
      else exp_ovr++;
      send_a(d, 1'b1);
    end
    drive_a(1'b1, BIT);
    @(negedge clk);
    head = exp_a[0];
    check_eq("full_count", 32'(cnt_a), 32'(4));
    check_eq("overrun_pulses", 32'(ovr_cnt_a - ovr_base), 32'(exp_ovr));
    check_eq("full_valid", 32'(valid_a), 32'(1));
    check_eq("full_head", 32'(data_a), 32'(head[9:2]));
    ready_a = 1'b1;
    wait_drain("drain_overrun");

    ready_a = 1'b0;
    send_a(8'($urandom), 1'b1);
    drive_a(1'b1, BIT);
    d = 8'($urandom);
    drive_a(1'b0, BIT);
    drive_a(d[7], BIT);
    drive_a(d[6], BIT);
    drive_a(d[5], BIT);
    drive_a(d[4], BIT / 2);
    @(negedge clk);
    check_eq("pre_reset_busy", 32'(busy_a), 32'(1));
    check_eq("pre_reset_valid", 32'(valid_a), 32'(1));
    @(posedge clk); #1; rst = 1'b1;
    exp_a.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    line_a = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    drive_a(1'b1, 2 * BIT);
    @(negedge clk);
    check_eq("post_reset_idle", 32'({valid_a, busy_a, cnt_a}), 32'(0));
    ready_a = 1'b1;
    d = 8'($urandom);
    exp_a.push_back({d, 2'b00});
    send_a(d, 1'b1);
    drive_a(1'b1, BIT);
    wait_drain("drain_after_reset");

    ovr_base = ovr_cnt_a + ovr_cnt_b;
    done_a = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          ra = 8'($urandom);
          exp_a.push_back({ra, 2'b00});
          send_a(ra, 1'b1);
          drive_a(1'b1, int'($urandom_range(1, 40)));
        end
        done_a = 1'b1;
      end
      begin
        while (!done_a) begin
          @(posedge clk); #1;
          ready_a = 1'($urandom_range(0, 1));
        end
        ready_a = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          rb = 5'($urandom);
          fb = 1'($urandom);
          exp_b.push_back({3'b000, rb, fb, 1'b0});
          send_b(rb, fb);
          drive_b(1'b1, int'($urandom_range(1, 40)));
        end
      end
    join
    wait_drain("drain_random");
    check_eq("random_no_overrun", 32'(ovr_cnt_a + ovr_cnt_b - ovr_base), 32'(0));
    check_eq("final_idle", 32'({busy_a, busy_b}), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- Parametrised UART receiver with 16x oversampling, metastability sync, majority-vote sampling and a buffered output.
- Configurable data width, bit order, parity mode and stop-bit count.
- Sits between the uart_master_tx pin and the uart_io command decoder. Delivers received bytes plus per-frame error status over a valid/ready handshake.

Parameters:
- CLK_FREQ, 20000000, core clock in Hz.
- BAUDRATE, 9600, bits per second.
- N_DATA_BITS, 8, data bits per frame; legal 5..8.
- LSB_FIRST, 0, bit order: 1 = LSB first, 0 = MSB first.
- PARITY_EN, 0, 1 = parity bit present after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored if PARITY_EN=0.
- STOP_BITS, 1, legal 1 or 2.
- FIFO_DEPTH, 4, output buffer entries; power of 2, at least 2.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial line, idle high, asynchronous to clk.
- rx_valid  out  1  FIFO head holds a frame.
- rx_ready  in  1  consumer accepts the head when valid and ready are both high.
- rx_data  out  8  head data; bits above N_DATA_BITS are zero; data is right-aligned.
- rx_parity_err  out  1  head frame failed parity.
- rx_frame_err  out  1  head frame had a stop bit sampled low.
- rx_overrun  out  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.
- rx_busy  out  1  FSM not in IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.

Behaviour:
- Reset (async assert, sync release):
  - sync flops = 1, FSM = IDLE, all counters = 0, FIFO empty.
  - Outputs: rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0, rx_busy=0, fifo_count=0.
  - Reset mid-frame discards the partial frame. No push occurs.
- Sync: uart_rx passes through 2 flops. The FSM uses only the synced value rxs.
- Oversample tick:
  - DIV = (CLK_FREQ + 8*BAUDRATE) / (16*BAUDRATE); 130 at the defaults.
  - The tick counter counts 0..DIV-1 and emits a tick at DIV-1.
  - It clears to 0 when IDLE detects rxs=0.
- Sample counter: s = 0..15 per bit, incremented on each tick. Bit value = majority of rxs at s = 7, 8, 9, evaluated at s = 9.
- FSM states:
  - IDLE: on rxs=0, go to START with s=0.
  - START: at s=9, majority 1 → false start, return to IDLE with no push. Majority 0 → continue; at s=15, go to DATA.
  - DATA: one bit per 16 samples.
    - LSB_FIRST=1: shift right into bit N_DATA_BITS-1.
    - LSB_FIRST=0: shift left into bit 0.
    - After N_DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: the sampled bit is compared against the XOR of the data bits (inverted if PARITY_ODD). A mismatch sets parity_err.
  - STOP: STOP_BITS bits. Any stop bit majority 0 sets frame_err.
    - At s=9 of the last stop bit: push {data, parity_err, frame_err} and return to IDLE.
    - The remaining half-bit is not waited for, which allows back-to-back frames.
  - A framing error does not abort the frame; data is still pushed with the flag set.
- FIFO:
  - Show-ahead. The push occurs on the cycle after the s=9 evaluation.
  - If the FIFO is empty, rx_valid rises the cycle after the push.
  - Pop occurs when rx_valid && rx_ready.
  - Full and no pop: the new frame is dropped, rx_overrun pulses for the push cycle, and contents are unchanged.
  - Full and pop on the same cycle: the push is accepted and fifo_count is unchanged.
  - Empty: rx_ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- rx_busy = (state != IDLE).

Test Plan:
- Defaults (8N1, MSB first, 9600 baud at 20 MHz): send "W" 0x57, then address 0xDEADBEEF MSB byte first → 5 entries 0x57, DE, AD, BE, EF; no error flags. rx_valid rises within 1 bit period plus 3 cycles after the mid-point of the stop bit.
- LSB_FIRST=1, N_DATA_BITS=5, PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2: send 0x15 with correct parity → rx_data=0x15, no errors. Send again with the parity bit flipped → rx_parity_err=1.
- Stop bit driven 0: send 0xA5 → rx_data=0xA5, rx_frame_err=1. The next frame 0x3C is received cleanly.
- Glitch: rx low for 4 oversample periods → false start, no push, rx_busy returns to 0.
- FIFO_DEPTH=4, rx_ready=0: send 5 frames → fifo_count=4, one rx_overrun pulse, frames 1–4 retained. Then raise rx_ready → 4 pops in order.
- Assert rst during data bit 3 → all outputs at reset values. The frame sent after release is received correctly.
